// File: rtl/w_stage_grf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w_stage_grf_pkg : MIPS opcode/funct names and writeback decode types
// Rev 1.0
// ---------------------------------------------------------------------------
package w_stage_grf_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;
  localparam logic [4:0] REG_RA    = 5'd31;

  typedef enum logic [2:0] {
    WSRC_NONE = 3'd0,
    WSRC_ALU  = 3'd1,
    WSRC_EXT  = 3'd2,
    WSRC_MEM  = 3'd3,
    WSRC_LOAD = 3'd4,
    WSRC_LINK = 3'd5
  } wsrc_e;

  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    wsrc_e      src;
  } wdec_t;

  function automatic logic is_rtype_alu(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/w_load_ext.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w_load_ext : selects and extends sub-word load data from the aligned word
// Rev 1.0
// ---------------------------------------------------------------------------
module w_load_ext
  import w_stage_grf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [5:0]    op_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [DW-1:0] dmout_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = dmout_i[8*addr_lo_i +: 8];
  assign w_half = dmout_i[16*addr_lo_i[1] +: 16];

  always_comb begin
    data_o = dmout_i;
    case (op_i)
      OP_LB:   data_o = {{(DW-8){w_byte[7]}}, w_byte};
      OP_LBU:  data_o = {{(DW-8){1'b0}}, w_byte};
      OP_LH:   data_o = {{(DW-16){w_half[15]}}, w_half};
      OP_LHU:  data_o = {{(DW-16){1'b0}}, w_half};
      default: data_o = dmout_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/w_stage_grf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// w_stage_grf : writeback decode, 32x32 GRF with write-then-read bypass
// Optional: GRF_TRACE_EN prints each committed register write.   Rev 1.0
// ---------------------------------------------------------------------------
module w_stage_grf
  import w_stage_grf_pkg::*;
#(
  parameter int DW       = 32,
  parameter int LINK_OFS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] W_pc,
  input  logic [31:0]   W_instr,
  input  logic [DW-1:0] W_alu,
  input  logic [DW-1:0] W_DMout,
  input  logic [DW-1:0] W_ext,
  input  logic          W_jump,
  input  logic [4:0]    D_a1,
  input  logic [4:0]    D_a2,
  output logic [DW-1:0] D_rd1,
  output logic [DW-1:0] D_rd2,
  output logic          W_we,
  output logic [4:0]    W_dst,
  output logic [DW-1:0] W_wdata
);

  logic [DW-1:0] grf_q [32];

  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic [4:0]    w_rt;
  logic [4:0]    w_rd;
  wdec_t         w_dec;
  logic [DW-1:0] w_link;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_data;
  logic          w_unused;

  assign w_op     = W_instr[31:26];
  assign w_rt     = W_instr[20:16];
  assign w_rd     = W_instr[15:11];
  assign w_fn     = W_instr[5:0];
  assign w_link   = W_pc + DW'(LINK_OFS);
  assign w_unused = ^{W_instr[25:21], W_instr[10:6]};

  w_load_ext #(.DW(DW)) u_load_ext (
    .op_i      (w_op),
    .addr_lo_i (W_alu[1:0]),
    .dmout_i   (W_DMout),
    .data_o    (w_load)
  );

  always_comb begin
    w_dec = '{wr: 1'b0, dst: 5'd0, src: WSRC_NONE};
    case (w_op)
      OP_RTYPE: begin
        if (is_rtype_alu(w_fn))   w_dec = '{wr: 1'b1, dst: w_rd, src: WSRC_ALU};
        else if (w_fn == FN_JALR) w_dec = '{wr: 1'b1, dst: w_rd, src: WSRC_LINK};
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
        w_dec = '{wr: 1'b1, dst: w_rt, src: WSRC_ALU};
      OP_LUI:  w_dec = '{wr: 1'b1, dst: w_rt, src: WSRC_EXT};
      OP_LW:   w_dec = '{wr: 1'b1, dst: w_rt, src: WSRC_MEM};
      OP_LB, OP_LBU, OP_LH, OP_LHU:
        w_dec = '{wr: 1'b1, dst: w_rt, src: WSRC_LOAD};
      OP_JAL:  w_dec = '{wr: 1'b1, dst: REG_RA, src: WSRC_LINK};
      OP_REGIMM: begin
        if ((w_rt == RT_BLTZAL || w_rt == RT_BGEZAL) && W_jump)
          w_dec = '{wr: 1'b1, dst: REG_RA, src: WSRC_LINK};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_data = '0;
    case (w_dec.src)
      WSRC_ALU:  w_data = W_alu;
      WSRC_EXT:  w_data = W_ext;
      WSRC_MEM:  w_data = W_DMout;
      WSRC_LOAD: w_data = w_load;
      WSRC_LINK: w_data = w_link;
      default:   w_data = '0;
    endcase
  end

  // $0 writes collapse to "no write" so downstream hazard logic never sees them
  assign W_we    = w_dec.wr && (w_dec.dst != 5'd0);
  assign W_dst   = W_we ? w_dec.dst : 5'd0;
  assign W_wdata = W_we ? w_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else if (W_we) begin
      grf_q[W_dst] <= W_wdata;
    end
  end

  assign D_rd1 = (D_a1 == 5'd0)              ? '0      :
                 (W_we && (D_a1 == W_dst))   ? W_wdata : grf_q[D_a1];
  assign D_rd2 = (D_a2 == 5'd0)              ? '0      :
                 (W_we && (D_a2 == W_dst))   ? W_wdata : grf_q[D_a2];

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (!reset && W_we) $display("@%h: $%d <= %h", W_pc, W_dst, W_wdata);
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_w_stage_grf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_w_stage_grf : directed vectors against a behavioural writeback/GRF model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_w_stage_grf;

  logic        clk;
  logic        reset;
  logic [31:0] W_pc, W_instr, W_alu, W_DMout, W_ext;
  logic        W_jump;
  logic [4:0]  D_a1, D_a2;
  logic [31:0] D_rd1, D_rd2, W_wdata;
  logic        W_we;
  logic [4:0]  W_dst;

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 0;

  logic [31:0] mreg [32];

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
  } exp_t;

  w_stage_grf #(.DW(32), .LINK_OFS(8)) dut (
    .clk(clk), .reset(reset), .W_pc(W_pc), .W_instr(W_instr), .W_alu(W_alu),
    .W_DMout(W_DMout), .W_ext(W_ext), .W_jump(W_jump), .D_a1(D_a1), .D_a2(D_a2),
    .D_rd1(D_rd1), .D_rd2(D_rd2), .W_we(W_we), .W_dst(W_dst), .W_wdata(W_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural meaning of the W-stage instruction, from raw MIPS encodings
  function automatic exp_t model(input logic [31:0] instr, pc, alu, dm, ext,
                                 input logic jmp);
    exp_t        e;
    int          op, rt, rd, fn;
    logic [31:0] b, h;
    op = int'(instr[31:26]); rt = int'(instr[20:16]);
    rd = int'(instr[15:11]); fn = int'(instr[5:0]);
    b = (dm >> (8 * alu[1:0])) & 32'hFF;
    h = (dm >> (alu[1] ? 16 : 0)) & 32'hFFFF;
    e = '0;
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) e = '{1'b1, 5'(rd), alu};
      else if (fn == 9) e = '{1'b1, 5'(rd), pc + 32'd8};
    end
    else if (op inside {[8:14]}) e = '{1'b1, 5'(rt), alu};
    else if (op == 15) e = '{1'b1, 5'(rt), ext};
    else if (op == 35) e = '{1'b1, 5'(rt), dm};
    else if (op == 32) e = '{1'b1, 5'(rt), b[7] ? (b | 32'hFFFFFF00) : b};
    else if (op == 36) e = '{1'b1, 5'(rt), b};
    else if (op == 33) e = '{1'b1, 5'(rt), h[15] ? (h | 32'hFFFF0000) : h};
    else if (op == 37) e = '{1'b1, 5'(rt), h};
    else if (op == 3)  e = '{1'b1, 5'd31, pc + 32'd8};
    else if (op == 1 && (rt == 16 || rt == 17) && jmp) e = '{1'b1, 5'd31, pc + 32'd8};
    if (e.dst == 5'd0) e.we = 1'b0;
    if (!e.we) e = '0;
    return e;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input exp_t e);
    if (a == 5'd0) return 32'd0;
    if (e.we && a == e.dst) return e.data;
    return mreg[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    e = model(W_instr, W_pc, W_alu, W_DMout, W_ext, W_jump);
    if (reset) for (int i = 0; i < 32; i++) mreg[i] <= 32'd0;
    else if (e.we) mreg[e.dst] <= e.data;
  end

  always @(negedge clk) begin
    exp_t e;
    if (check_en) begin
      e = model(W_instr, W_pc, W_alu, W_DMout, W_ext, W_jump);
      chk("W_we",    {31'd0, W_we},  {31'd0, e.we});
      chk("W_dst",   {27'd0, W_dst}, {27'd0, e.dst});
      chk("W_wdata", W_wdata, e.data);
      chk("D_rd1",   D_rd1, mread(D_a1, e));
      chk("D_rd2",   D_rd2, mread(D_a2, e));
    end
  end

  task automatic step(input logic r, input logic [31:0] instr, pc, alu, dm, ext,
                      input logic jmp, input logic [4:0] a1, a2);
    @(posedge clk);
    #1;
    reset = r; W_instr = instr; W_pc = pc; W_alu = alu; W_DMout = dm;
    W_ext = ext; W_jump = jmp; D_a1 = a1; D_a2 = a2;
    #3;
  endtask

  localparam logic [31:0] ADDU8  = 32'h012A4021;
  localparam logic [31:0] LB4    = 32'h80040000;
  localparam logic [31:0] LBU4   = 32'h90040000;
  localparam logic [31:0] LH4    = 32'h84040000;
  localparam logic [31:0] LHU4   = 32'h94040000;
  localparam logic [31:0] JAL    = 32'h0C000000;
  localparam logic [31:0] BLTZAL = 32'h04100000;
  localparam logic [31:0] BGEZAL = 32'h04110000;
  localparam logic [31:0] ORI0   = 32'h34000005;
  localparam logic [31:0] DM     = 32'h80FF7F01;

  initial begin
    reset = 1'b1; W_instr = 0; W_pc = 0; W_alu = 0; W_DMout = 0;
    W_ext = 0; W_jump = 0; D_a1 = 0; D_a2 = 0;
    @(posedge clk);
    step(0, 0, 32'h3000, 0, 0, 0, 0, 5'd5, 5'd31);
    check_en = 1;
    chk("reset_rd1", D_rd1, 32'd0);
    chk("reset_rd2", D_rd2, 32'd0);
    chk("bubble_we", {31'd0, W_we}, 32'd0);

    step(0, ADDU8, 32'h3004, 32'h12345678, 0, 0, 0, 5'd8, 5'd9);
    chk("addu_we",  {31'd0, W_we}, 32'd1);
    chk("addu_dst", {27'd0, W_dst}, 32'd8);
    chk("addu_byp", D_rd1, 32'h12345678);
    step(0, 0, 32'h3008, 0, 0, 0, 0, 5'd8, 5'd8);
    chk("addu_grf", D_rd1, 32'h12345678);

    step(0, LB4,  32'h300C, 32'h00001003, DM, 0, 0, 5'd4, 5'd8);
    chk("lb3",  W_wdata, 32'hFFFFFF80);
    step(0, LBU4, 32'h3010, 32'h00001003, DM, 0, 0, 5'd4, 5'd4);
    chk("lbu3", W_wdata, 32'h00000080);
    step(0, LH4,  32'h3014, 32'h00001000, DM, 0, 0, 5'd4, 5'd0);
    chk("lh0",  W_wdata, 32'h00007F01);
    step(0, LH4,  32'h3018, 32'h00001002, DM, 0, 0, 5'd4, 5'd8);
    chk("lh2",  W_wdata, 32'hFFFF80FF);
    step(0, LHU4, 32'h301C, 32'h00001002, DM, 0, 0, 5'd4, 5'd8);
    chk("lhu2", W_wdata, 32'h000080FF);
    step(0, LB4,  32'h3020, 32'h00001001, DM, 0, 0, 5'd4, 5'd8);
    chk("lb1",  W_wdata, 32'h0000007F);
    step(0, LBU4, 32'h3024, 32'h00001002, DM, 0, 0, 5'd4, 5'd8);
    chk("lbu2", W_wdata, 32'h000000FF);

    step(0, JAL, 32'h3000, 0, 0, 0, 0, 5'd31, 5'd31);
    chk("jal_dst",  {27'd0, W_dst}, 32'd31);
    chk("jal_data", W_wdata, 32'h3008);
    chk("jal_both", D_rd2, 32'h3008);
    step(0, 32'h34070000, 32'h3100, 32'h0000ABCD, 0, 0, 0, 5'd31, 5'd7);
    step(0, BLTZAL, 32'h3000, 0, 0, 0, 0, 5'd31, 5'd7);
    chk("bltzal_nt", {31'd0, W_we}, 32'd0);
    step(0, BLTZAL, 32'h3000, 0, 0, 0, 1, 5'd7, 5'd31);
    chk("bltzal_t", W_wdata, 32'h3008);
    step(0, BGEZAL, 32'h4000, 0, 0, 0, 1, 5'd31, 5'd7);
    chk("bgezal_t", D_rd1, 32'h4008);
    step(0, 32'h03E02809, 32'h5000, 0, 0, 0, 0, 5'd5, 5'd31);
    chk("jalr", D_rd1, 32'h5008);

    step(0, ORI0, 32'h3200, 32'h5, 0, 0, 0, 5'd0, 5'd8);
    chk("ori0_we",  {31'd0, W_we}, 32'd0);
    chk("ori0_dst", {27'd0, W_dst}, 32'd0);
    chk("ori0_rd1", D_rd1, 32'd0);
    step(0, 32'h3C0B0000, 32'h3204, 0, 0, 32'hBEEF0000, 0, 5'd11, 5'd7);
    chk("lui", D_rd1, 32'hBEEF0000);
    step(0, 32'h8C0C0000, 32'h3208, 32'h2000, 32'hCAFEF00D, 0, 0, 5'd12, 5'd11);
    chk("lw", W_wdata, 32'hCAFEF00D);
    step(0, 32'hAC0C0000, 32'h320C, 32'h2000, 32'h0, 0, 0, 5'd12, 5'd4);
    chk("sw_nowr", {31'd0, W_we}, 32'd0);
    step(0, 32'h03E00008, 32'h3210, 32'h77, 0, 0, 0, 5'd12, 5'd31);
    step(0, 32'h10000004, 32'h3214, 32'h77, 0, 0, 0, 5'd4, 5'd5);

    for (int r = 1; r < 32; r++)
      step(0, 32'h24000000 | (r << 16), 32'h6000 + 4 * r,
           (r * 32'h01010101) ^ 32'hA5, 0, 0, 0, 5'(r), 5'(r - 1));
    for (int r = 0; r < 32; r += 2)
      step(0, 0, 32'h7000, 0, 0, 0, 0, 5'(r), 5'(r + 1));
    chk("grf_r30", D_rd1, (30 * 32'h01010101) ^ 32'hA5);

    step(1, ADDU8, 32'h3300, 32'hDEADBEEF, 0, 0, 0, 5'd8, 5'd8);
    step(0, 0, 32'h3304, 0, 0, 0, 0, 5'd8, 5'd31);
    chk("rst_drop", D_rd1, 32'd0);
    chk("rst_clr",  D_rd2, 32'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
